// File: rtl/vdp_reg_write_arbiter.sv
// Copper/host register-write arbiter feeding the VDP register-file write port; optional drop counter under VDP_REG_ARB_DROP_COUNT_EN.
// Latency: a write captured in the FIFO or host holding register at edge N appears on out_write_* at edge N+1 at the earliest.
// Backpressure: out_write_ready stalls the output stage; copper writes arriving while the FIFO is full are dropped and flagged.

// Generic FIFO: DEPTH (power of 2) entries of WIDTH bits, pointers wrap modulo DEPTH.
// Latency: an entry pushed at edge N is poppable at edge N+1; no push-to-pop bypass.
// Backpressure: full/empty come from the registered count; a push while full is ignored.
module vdp_reg_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Arbitrates buffered copper writes and a single held host write onto one register-file write port.
// Latency: one cycle from FIFO/holding-register capture to output; one write per cycle with out_write_ready high.
// Backpressure: valid/ready output stage; copper uses cop_write_ready (drops when full), host uses host_write_ready.
module vdp_reg_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  cop_write_address,
    input  logic [15:0] cop_write_data,
    input  logic        cop_write_en,
    output logic        cop_write_ready,
    input  logic [5:0]  host_write_address,
    input  logic [15:0] host_write_data,
    input  logic        host_write_en,
    output logic        host_write_ready,
    output logic [5:0]  out_write_address,
    output logic [15:0] out_write_data,
    output logic        out_write_en,
    input  logic        out_write_ready,
    output logic        overflow,
    input  logic        overflow_clear,
    output logic [7:0]  drop_count
);
    typedef struct packed {
        logic [5:0]  address;
        logic [15:0] data;
    } reg_wr_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    reg_wr_t         cop_wr;
    reg_wr_t         cop_head;
    reg_wr_t         host_hold;
    reg_wr_t         out_wr;
    logic            fifo_full;
    logic            fifo_empty;
    logic            host_vld;
    logic            out_vld;
    logic            load_ok;
    logic            grant_cop;
    logic            grant_host;
    logic            cop_push;
    logic            cop_drop;
    logic            starved;
    logic [SW-1:0]   starve_cnt;

    assign cop_wr   = {cop_write_address, cop_write_data};
    assign cop_push = cop_write_en && !fifo_full;
    assign cop_drop = cop_write_en && fifo_full;

    vdp_reg_fifo #(
        .WIDTH ($bits(reg_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cop_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (cop_push),
        .push_dat (cop_wr),
        .pop      (grant_cop),
        .pop_dat  (cop_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Copper wins ties until the host has been passed over STARVE_LIMIT times in a row.
    assign starved    = (starve_cnt == SW'(STARVE_LIMIT));
    assign load_ok    = !out_vld || out_write_ready;
    assign grant_cop  = load_ok && !fifo_empty && (!host_vld || !starved);
    assign grant_host = load_ok && host_vld && (fifo_empty || starved);

    assign cop_write_ready   = !fifo_full;
    assign host_write_ready  = !host_vld;
    assign out_write_en      = out_vld;
    assign out_write_address = out_wr.address;
    assign out_write_data    = out_wr.data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld    <= 1'b0;
            out_wr     <= '0;
            host_vld   <= 1'b0;
            host_hold  <= '0;
            starve_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (load_ok) begin
                out_vld <= grant_cop || grant_host;
                if (grant_host)
                    out_wr <= host_hold;
                else if (grant_cop)
                    out_wr <= cop_head;
            end

            if (grant_host) begin
                host_vld <= 1'b0;
            end else if (host_write_en && !host_vld) begin
                host_vld  <= 1'b1;
                host_hold <= {host_write_address, host_write_data};
            end

            if (!host_vld || grant_host)
                starve_cnt <= '0;
            else if (grant_cop && !starved)
                starve_cnt <= starve_cnt + 1'b1;

            // A drop in the same cycle as a clear keeps the flag set.
            if (cop_drop)
                overflow <= 1'b1;
            else if (overflow_clear)
                overflow <= 1'b0;
        end
    end

`ifdef VDP_REG_ARB_DROP_COUNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_cnt <= 8'h00;
        else if (overflow_clear)
            drop_cnt <= cop_drop ? 8'h01 : 8'h00;
        else if (cop_drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'h01;
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = 8'h00;
`endif
endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// Directed bench for vdp_reg_write_arbiter: latency, FIFO fill/drop, starvation, tie-break, async reset, drop counter.
module tb_vdp_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  cop_write_address;
    logic [15:0] cop_write_data;
    logic        cop_write_en;
    logic        cop_write_ready;
    logic [5:0]  host_write_address;
    logic [15:0] host_write_data;
    logic        host_write_en;
    logic        host_write_ready;
    logic [5:0]  out_write_address;
    logic [15:0] out_write_data;
    logic        out_write_en;
    logic        out_write_ready;
    logic        overflow;
    logic        overflow_clear;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

`ifdef VDP_REG_ARB_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    vdp_reg_write_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cop_write_address  (cop_write_address),
        .cop_write_data     (cop_write_data),
        .cop_write_en       (cop_write_en),
        .cop_write_ready    (cop_write_ready),
        .host_write_address (host_write_address),
        .host_write_data    (host_write_data),
        .host_write_en      (host_write_en),
        .host_write_ready   (host_write_ready),
        .out_write_address  (out_write_address),
        .out_write_data     (out_write_data),
        .out_write_en       (out_write_en),
        .out_write_ready    (out_write_ready),
        .overflow           (overflow),
        .overflow_clear     (overflow_clear),
        .drop_count         (drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cop_set(input int k);
        cop_write_en      = 1'b1;
        cop_write_address = 6'(k);
        cop_write_data    = 16'hC000 + 16'(k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n            = 1'b0;
        cop_write_address  = '0;
        cop_write_data     = '0;
        cop_write_en       = 1'b0;
        host_write_address = '0;
        host_write_data    = '0;
        host_write_en      = 1'b0;
        out_write_ready    = 1'b1;
        overflow_clear     = 1'b0;

        // Reset state
        #12;
        chk("rst_out_en", out_write_en, 0);
        chk("rst_out_addr", out_write_address, 0);
        chk("rst_out_data", out_write_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_count", drop_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rst_cop_rdy", cop_write_ready, 1);
        chk("rst_host_rdy", host_write_ready, 1);

        // Single copper write: visible one cycle after capture, for exactly one cycle
        cop_write_en = 1'b1; cop_write_address = 6'h05; cop_write_data = 16'hBEEF;
        tick();
        cop_write_en = 1'b0;
        chk("t1_no_bypass", out_write_en, 0);
        tick();
        chk("t1_out_en", out_write_en, 1);
        chk("t1_out_addr", out_write_address, 6'h05);
        chk("t1_out_data", out_write_data, 16'hBEEF);
        tick();
        chk("t1_out_en_drop", out_write_en, 0);

        // Fill with output stalled: 1 in output stage + 4 in FIFO, 6th dropped
        out_write_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t2_cop_rdy", cop_write_ready, (i < 5) ? 1 : 0);
            cop_write_en = 1'b1; cop_write_address = 6'(8'h10 + i); cop_write_data = 16'hA000 + 16'(i);
            tick();
        end
        cop_write_en = 1'b0;
        chk("t2_overflow", overflow, 1);
        chk("t2_drop_count", drop_count, DC_EN ? 1 : 0);
        chk("t2_cop_rdy_full", cop_write_ready, 0);
        chk("t2_held_addr", out_write_address, 6'h10);
        tick();
        chk("t2_still_held", out_write_data, 16'hA000);
        out_write_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t2_order_en", out_write_en, 1);
            chk("t2_order_addr", out_write_address, 8'h10 + k);
            chk("t2_order_data", out_write_data, 16'hA000 + 16'(k));
            tick();
        end
        chk("t2_drained", out_write_en, 0);
        chk("t2_cop_rdy_back", cop_write_ready, 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        chk("t2_ovf_clr", overflow, 0);
        chk("t2_dc_clr", drop_count, 0);

        // Starvation: host waits through exactly 8 copper grants
        cop_set(0);
        tick();
        cop_set(1);
        host_write_en = 1'b1; host_write_address = 6'h3F; host_write_data = 16'h1234;
        tick();
        host_write_en = 1'b0;
        chk("t3_host_rdy_lo", host_write_ready, 0);
        chk("t3_c0", out_write_address, 0);
        for (int k = 1; k <= 8; k++) begin
            cop_set(k + 1);
            tick();
            chk("t3_cop_addr", out_write_address, k);
            chk("t3_cop_data", out_write_data, 16'hC000 + 16'(k));
            chk("t3_host_wait", host_write_ready, 0);
        end
        cop_set(10);
        tick();
        chk("t3_host_addr", out_write_address, 6'h3F);
        chk("t3_host_data", out_write_data, 16'h1234);
        chk("t3_host_rdy_hi", host_write_ready, 1);
        cop_write_en = 1'b0;
        tick();
        chk("t3_c9", out_write_address, 9);
        tick();
        chk("t3_c10", out_write_address, 10);
        tick();
        chk("t3_idle", out_write_en, 0);

        // Simultaneous arrival into an idle arbiter: copper first, host second
        cop_write_en = 1'b1; cop_write_address = 6'h21; cop_write_data = 16'h1111;
        host_write_en = 1'b1; host_write_address = 6'h22; host_write_data = 16'h2222;
        tick();
        cop_write_en = 1'b0; host_write_en = 1'b0;
        chk("t4_none_yet", out_write_en, 0);
        tick();
        chk("t4_first_cop", out_write_address, 6'h21);
        chk("t4_first_data", out_write_data, 16'h1111);
        tick();
        chk("t4_second_host", out_write_address, 6'h22);
        chk("t4_second_data", out_write_data, 16'h2222);
        chk("t4_host_rdy", host_write_ready, 1);
        tick();
        chk("t4_idle", out_write_en, 0);

        // Async reset mid-stall with 3 FIFO entries and a held host write
        out_write_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cop_write_en = 1'b1; cop_write_address = 6'(8'h30 + i); cop_write_data = 16'h5500 + 16'(i);
            if (i == 3) begin
                host_write_en = 1'b1; host_write_address = 6'h2A; host_write_data = 16'h7777;
            end
            tick();
        end
        cop_write_en = 1'b0; host_write_en = 1'b0;
        chk("t5_stalled", out_write_en, 1);
        chk("t5_host_held", host_write_ready, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_out_en", out_write_en, 0);
        chk("t5_rst_out_addr", out_write_address, 0);
        chk("t5_rst_cop_rdy", cop_write_ready, 1);
        chk("t5_rst_host_rdy", host_write_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        out_write_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_stale", out_write_en, 0);
        end
        chk("t5_host_rdy_after", host_write_ready, 1);

        // Drops: 5 accepted, then 300 dropped
        out_write_ready = 1'b0;
        cop_write_en = 1'b1; cop_write_address = 6'h01; cop_write_data = 16'h0001;
        for (int i = 0; i < 305; i++) tick();
        chk("t6_overflow", overflow, 1);
        chk("t6_drop_sat", drop_count, DC_EN ? 8'hFF : 8'h00);
        overflow_clear = 1'b1;
        tick();
        chk("t6_clr_drop_ovf", overflow, 1);
        chk("t6_clr_drop_dc", drop_count, DC_EN ? 1 : 0);
        cop_write_en = 1'b0;
        tick();
        overflow_clear = 1'b0;
        chk("t6_clr_ovf", overflow, 0);
        chk("t6_clr_dc", drop_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vdp_reg_write_arbiter.md
Name: vdp_reg_write_arbiter

Overview:
- Responder end of the copper register-write interface.
- Accepts raster-timed register writes from the copper and CPU/host register writes, and buffers copper writes in a small FIFO.
- Arbitrates both sources onto the single VDP register-file write port, using a valid/ready output stage.
- Sits between the copper and host bus on one side and the VDP register decode on the other.

Parameters:
- FIFO_DEPTH, 4: copper write FIFO entries; must be a power of 2, minimum 2.
- STARVE_LIMIT, 8: number of consecutive copper grants allowed while a host write is pending before the host is forced through.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cop_write_address  in  6  copper register address
- cop_write_data  in  16  copper register data
- cop_write_en  in  1  copper write strobe; single-cycle pulse per write
- cop_write_ready  out  1  FIFO can accept; registered
- host_write_address  in  6  host register address
- host_write_data  in  16  host register data
- host_write_en  in  1  host write request
- host_write_ready  out  1  host holding register empty
- out_write_address  out  6  register-file address
- out_write_data  out  16  register-file data
- out_write_en  out  1  output valid
- out_write_ready  in  1  register file accepts
- overflow  out  1  sticky: a copper write was dropped
- overflow_clear  in  1  clears overflow
- drop_count  out  8  dropped-write counter (optional feature)

Behaviour:
- Reset: one clock; reset_n is asynchronous and active-low. Asserting reset_n=0 at any time, including mid-transfer, immediately clears the following:
  - FIFO pointers and count → 0
  - host holding register → empty
  - out_write_en → 0; out_write_address → 0; out_write_data → 0
  - overflow → 0; drop_count → 0; starvation counter → 0
  - cop_write_ready → 1 and host_write_ready → 1 in the first cycle after release
- Copper push:
  - When cop_write_en && cop_write_ready, {address, data} is pushed into the FIFO.
  - cop_write_ready = !full, computed from the registered count. It stays 0 when the FIFO is full, even if a pop happens in the same cycle.
  - When cop_write_en && !cop_write_ready, the write is dropped, overflow is set, and drop_count is incremented.
- Host accept:
  - When host_write_en && host_write_ready, the holding register loads and host_write_ready goes 0 from the next cycle.
  - host_write_ready returns to 1 in the cycle after the held write is granted into the output stage.
- Output stage:
  - The stage loads when it is empty (out_write_en=0) or is being accepted this cycle (out_write_en && out_write_ready).
  - While out_write_en=1 and out_write_ready=0, address and data are held stable.
- Arbitration, evaluated whenever the output stage can load:
  - FIFO non-empty and host empty → grant copper.
  - Host pending and FIFO empty → grant host.
  - Both pending → grant copper, unless the starvation counter equals STARVE_LIMIT, in which case grant host.
  - Starvation counter: increments on each copper grant made while the host is pending, saturating at STARVE_LIMIT. Resets to 0 on a host grant or when no host write is pending.
  - Neither pending → out_write_en goes to 0 after the current item is accepted.
- Latency:
  - A write entering the FIFO or holding register at edge N is visible on out_write_* at edge N+1 at the earliest, when the output stage is free.
  - Throughput is 1 write per cycle with out_write_ready held high.
- Simultaneous events:
  - Push and pop on a non-full FIFO in the same cycle: count is unchanged, and both operations take effect.
  - A push into an empty FIFO is not bypassed to the output in the same cycle.
  - overflow_clear and a new drop in the same cycle: overflow stays 1, and the drop is counted.
- Ordering:
  - Copper writes leave in FIFO order.
  - Host writes are never reordered among themselves; there is at most one outstanding host write.
- Pointer width: log2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH. Count width: log2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: VDP_REG_ARB_DROP_COUNT_EN
- Defined: drop_count is an 8-bit counter that increments per dropped copper write, saturates at 8'hFF, and clears on overflow_clear or reset. A clear and a drop in the same cycle → drop_count = 1.
- Undefined: drop_count is tied to 8'h00 and no counter logic is generated. overflow behaviour is unchanged.

Test Plan:
- Single copper write {addr 6'h05, data 16'hBEEF} with out_write_ready=1 → out_write_en high for exactly 1 cycle, one cycle later, carrying 05/BEEF.
- out_write_ready=0; push 5 copper writes with FIFO_DEPTH=4 → 4 are accepted plus 1 loaded into the output stage. cop_write_ready drops at the correct cycle, a 6th push sets overflow and drop_count=1, and output order matches input order.
- Continuous copper pushes every cycle with a host write pending (addr 6'h3F, data 16'h1234) → host granted after exactly 8 copper grants; host_write_ready returns to 1 in the next cycle.
- Host and copper both arrive into an idle arbiter in the same cycle with starvation counter 0 → copper output first, host second.
- Assert reset_n=0 mid-stall with the FIFO holding 3 entries → out_write_en=0 immediately, count 0, both ready outputs 1 after release, and no stale writes emerge.
- Without the macro, force 300 drops → overflow=1 and drop_count=0. With the macro → drop_count saturates at 8'hFF; overflow_clear resets both to 0.
